can_frame_rx: RTL
=================

# can_frame_rx

Receive-side CAN 2.0 frame parser sitting directly downstream of `rx_pipeline`. Consumes one destuffed bit per `bit_valid` strobe, walks the frame fields from SOF to EOF, checks CRC-15 and fixed-form bits, and presents a complete frame (ID, IDE, RTR, DLC, data) with a one-cycle valid strobe. Drives `stuff_bypass` back into `rx_pipeline` for the fixed-form tail of the frame.

## Interface
Parameters:
- `IDLE_BITS`, 11, consecutive recessive bits required for bus integration before an SOF is accepted.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `bit_valid`  in  1  one-cycle strobe; `rx_bit` is valid. Connects to `rx_pipeline.updated_bit`.
- `rx_bit`  in  1  destuffed bit. 0 = dominant. Connects to `next_bit`.
- `stuff_error`  in  1  stuff error from `rx_pipeline`, sampled with `bit_valid`.
- `stuff_bypass`  out  1  registered; 1 disables destuffing upstream.
- `busy`  out  1  1 from SOF until frame end or error.
- `ack_slot`  out  1  one-cycle pulse when the CRC delimiter is accepted with a good CRC; a transmitter may use it to drive ACK.
- `frame_valid`  out  1  one-cycle pulse; frame outputs updated.
- `frame_id`  out  29  standard ID in [10:0] (upper bits 0), or full extended ID.
- `frame_ide`, `frame_rtr`  out  1 each.
- `frame_dlc`  out  4  raw received DLC.
- `frame_data`  out  64  first byte in [63:56]; unreceived bytes 0.
- `crc_error`, `form_error`, `stuff_err_flag`  out  1 each  one-cycle error pulses.

## Operation
- All state advances only on clocks where `bit_valid`=1; other cycles hold.
- States: IDLE, ID_A (11), SRR_RTR, IDE, ID_B (18), RTR_EXT, R1, R0, DLC (4), DATA, CRC (15), CRC_DEL, ACK, ACK_DEL, EOF (7), ERROR.
- IDLE: count consecutive recessive bits, saturating at `IDLE_BITS`; a dominant bit with count = `IDLE_BITS` is SOF → ID_A; a dominant bit with lower count clears the count.
- IDE=0: SRR_RTR bit is RTR → R0 → DLC. IDE=1: SRR_RTR is SRR → ID_B → RTR_EXT → R1 → R0 → DLC. Reserved bits are accepted at any value.
- DATA length = 8 × min(DLC, 8) bits; 0 if RTR=1 (DATA skipped). DLC 9–15 → 8 bytes.
- CRC-15, polynomial 0x4599, initialised to 0 at SOF, shifted MSB-first over SOF through the last data bit, then through the 15 received CRC bits; remainder ≠ 0 at CRC_DEL → `crc_error`.
- Form errors (`form_error`): CRC_DEL, ACK_DEL or any EOF bit dominant. ACK accepted at any value.
- `stuff_error` with `stuff_bypass`=0 in any non-IDLE/ERROR state → `stuff_err_flag`.
- Any error → ERROR: `stuff_bypass`=1, wait `IDLE_BITS` consecutive recessive bits → IDLE with integration satisfied. Errors are not reported in IDLE or ERROR.
- On the 7th EOF bit accepted recessive: latch frame outputs, pulse `frame_valid`, → IDLE with integration satisfied (`IDLE_BITS` counted from EOF). Frame outputs hold until the next `frame_valid`; errored frames never update them.

## Timing
- Reset values: state IDLE with count 0, `stuff_bypass`=1, `busy`=0, all pulses 0, all frame outputs 0.
- `stuff_bypass` = 0 from the clock accepting SOF through the last CRC bit; it goes 1 on the clock that accepts the 15th CRC bit, i.e. before the CRC_DEL strobe. `bit_valid` strobes are ≥2 clocks apart.
- `frame_valid`, `ack_slot` and error pulses are registered and assert on the clock after the deciding `bit_valid`, for exactly one cycle.
- `rst` mid-frame: discard all partial fields and return to reset values the next clock; no pulses.
- Simultaneous `stuff_error` and a form violation on the same bit: only `stuff_err_flag` is reported.

## Configuration
- `CAN_EXT_ID_EN` defined: extended frames are parsed as above.
- Undefined: ID_B, RTR_EXT and R1 are not built. IDE=1 → `form_error` → ERROR. `frame_ide` is tied to 0 and `frame_id[28:11]` to 0.

## Test plan
- Idle for 11 recessive bits, then standard frame ID 0x123, DLC 2, data 0xAB 0xCD with valid CRC, stuffed through `rx_pipeline` → one `frame_valid`, `frame_id`=0x123, `frame_ide`=0, `frame_dlc`=2, `frame_data`=0xABCD_0000_0000_0000, and `ack_slot` one pulse.
- Extended frame ID 0x1234567, DLC 1, data 0x55 (`CAN_EXT_ID_EN` defined) → `frame_id`=0x1234567, `frame_ide`=1, `frame_data[63:56]`=0x55. With the macro undefined → `form_error`, no `frame_valid`.
- RTR standard frame ID 0x7FF, DLC 4 → `frame_rtr`=1, `frame_dlc`=4, `frame_data`=0, CRC accepted.
- Same first frame with one CRC bit flipped → `crc_error` pulse, no `ack_slot`, no `frame_valid`; previous outputs unchanged; a following good frame is received after 11 recessive bits.
- Six equal bits injected inside ID_A → `stuff_err_flag` pulse, `stuff_bypass`=1 until 11 recessive bits seen. Dominant bit in EOF bit 3 → `form_error`.
- `rst` asserted during DATA → next clock all outputs at reset values. An SOF without 11 prior recessive bits is ignored.

Source files
------------

// File: rtl/can_frame_rx_if.sv
// ---------------------------------------------------------------------------
// can_frame_rx_if
// Bundles the bit stream coming from rx_pipeline and the parsed-frame results
// of can_frame_rx.
//   Upstream side  : bit_valid, rx_bit, stuff_error (into the parser)
//                    stuff_bypass (back to rx_pipeline)
//   Frame results  : busy, ack_slot, frame_valid, frame_id/ide/rtr/dlc/data
//   Error pulses   : crc_error, form_error, stuff_err_flag
// Modports:
//   slave  - the parser (consumes bits, produces results)
//   master - the environment (drives bits, observes results)
// ---------------------------------------------------------------------------
interface can_frame_rx_if;
  logic        bit_valid;
  logic        rx_bit;
  logic        stuff_error;
  logic        stuff_bypass;
  logic        busy;
  logic        ack_slot;
  logic        frame_valid;
  logic [28:0] frame_id;
  logic        frame_ide;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        crc_error;
  logic        form_error;
  logic        stuff_err_flag;

  modport slave (
    input  bit_valid, rx_bit, stuff_error,
    output stuff_bypass, busy, ack_slot, frame_valid, frame_id, frame_ide,
           frame_rtr, frame_dlc, frame_data, crc_error, form_error,
           stuff_err_flag
  );

  modport master (
    output bit_valid, rx_bit, stuff_error,
    input  stuff_bypass, busy, ack_slot, frame_valid, frame_id, frame_ide,
           frame_rtr, frame_dlc, frame_data, crc_error, form_error,
           stuff_err_flag
  );
endinterface

// File: rtl/can_frame_rx.sv
// ---------------------------------------------------------------------------
// can_frame_rx
// CAN 2.0 receive frame parser. Consumes one destuffed bit per bit_valid
// strobe, walks SOF..EOF, checks CRC-15 and the fixed-form tail, and presents
// the received frame with a one-cycle frame_valid strobe.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - can_frame_rx_if.slave: bit stream in, stuff_bypass back upstream,
//          frame fields and one-cycle status/error pulses out
// Parameter:
//   IDLE_BITS - consecutive recessive bits needed for bus integration
// Build option:
//   CAN_EXT_ID_EN - when defined, extended (29-bit ID) frames are parsed;
//                   otherwise IDE=1 is a form error and frame_ide is 0.
// ---------------------------------------------------------------------------
module can_frame_rx #(
  parameter int IDLE_BITS = 11
) (
  input logic           clk,
  input logic           rst,
  can_frame_rx_if.slave bus
);

  localparam int CW = $clog2(IDLE_BITS + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_BITS);
`ifdef CAN_EXT_ID_EN
  localparam int IDW = 29;
`else
  localparam int IDW = 11;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_EXT, S_R1, S_R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [14:0]     crc_q, crc_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            rtr_q, rtr_d;
  logic [3:0]      dlc_q, dlc_d;
  logic [63:0]     data_q, data_d;
  logic            bypass_q, bypass_d;

  logic            ack_q, ack_d;
  logic            fv_q, fv_d;
  logic            crc_err_q, crc_err_d;
  logic            form_err_q, form_err_d;
  logic            stuff_err_q, stuff_err_d;

  logic [28:0]     fid_q, fid_d;
  logic            frtr_q, frtr_d;
  logic [3:0]      fdlc_q, fdlc_d;
  logic [63:0]     fdata_q, fdata_d;
`ifdef CAN_EXT_ID_EN
  logic            ide_q, ide_d;
  logic            fide_q, fide_d;
`endif

  logic            crc_nxt;
  logic [14:0]     crc_shift;
  logic [6:0]      data_len;
  logic            in_frame;
  logic            go_error;

  // MSB-first CRC-15 step over the current bit; feeding the received CRC
  // through the same register leaves a zero remainder on a good frame.
  assign crc_nxt   = bus.rx_bit ^ crc_q[14];
  assign crc_shift = {crc_q[13:0], 1'b0} ^ (crc_nxt ? 15'h4599 : 15'h0000);

  // Data field length in bits, taken from the DLC as it is being completed so
  // the decision to skip DATA can be made on the last DLC bit.
  always_comb begin
    data_len = 7'd0;
    if (!rtr_q) begin
      data_len = dlc_d[3] ? 7'd64 : {1'b0, dlc_d[2:0], 3'b000};
    end
  end

  assign in_frame = (state_q != S_IDLE) && (state_q != S_ERROR);

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    id_d        = id_q;
    rtr_d       = rtr_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    bypass_d    = bypass_q;
    fid_d       = fid_q;
    frtr_d      = frtr_q;
    fdlc_d      = fdlc_q;
    fdata_d     = fdata_q;
`ifdef CAN_EXT_ID_EN
    ide_d       = ide_q;
    fide_d      = fide_q;
`endif
    ack_d       = 1'b0;
    fv_d        = 1'b0;
    crc_err_d   = 1'b0;
    form_err_d  = 1'b0;
    stuff_err_d = 1'b0;
    go_error    = 1'b0;

    if (bus.bit_valid) begin
      // A stuff error outranks any form violation seen on the same bit.
      if (in_frame && bus.stuff_error && !bypass_q) begin
        stuff_err_d = 1'b1;
        go_error    = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.rx_bit) begin
              if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
            end else if (idle_cnt_q == IDLE_MAX) begin
              // SOF: clear every partial field; SOF itself shifts a zero
              // into a zero CRC, so the CRC simply starts at 0.
              state_d  = S_ID_A;
              cnt_d    = 7'd0;
              crc_d    = 15'd0;
              id_d     = '0;
              rtr_d    = 1'b0;
              dlc_d    = 4'd0;
              data_d   = 64'd0;
              bypass_d = 1'b0;
`ifdef CAN_EXT_ID_EN
              ide_d    = 1'b0;
`endif
            end else begin
              idle_cnt_d = '0;
            end
          end
          S_ID_A: begin
            id_d  = {id_q[IDW-2:0], bus.rx_bit};
            crc_d = crc_shift;
            if (cnt_q == 7'd10) begin
              state_d = S_SRR_RTR;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_SRR_RTR: begin
            // RTR for base frames; SRR for extended ones (overwritten later).
            rtr_d   = bus.rx_bit;
            crc_d   = crc_shift;
            state_d = S_IDE;
          end
          S_IDE: begin
            crc_d = crc_shift;
            if (!bus.rx_bit) begin
              state_d = S_R0;
            end else begin
`ifdef CAN_EXT_ID_EN
              ide_d   = 1'b1;
              state_d = S_ID_B;
              cnt_d   = 7'd0;
`else
              form_err_d = 1'b1;
              go_error   = 1'b1;
`endif
            end
          end
`ifdef CAN_EXT_ID_EN
          S_ID_B: begin
            id_d  = {id_q[IDW-2:0], bus.rx_bit};
            crc_d = crc_shift;
            if (cnt_q == 7'd17) begin
              state_d = S_RTR_EXT;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_RTR_EXT: begin
            rtr_d   = bus.rx_bit;
            crc_d   = crc_shift;
            state_d = S_R1;
          end
          S_R1: begin
            crc_d   = crc_shift;
            state_d = S_R0;
          end
`endif
          S_R0: begin
            crc_d   = crc_shift;
            state_d = S_DLC;
            cnt_d   = 7'd0;
          end
          S_DLC: begin
            dlc_d = {dlc_q[2:0], bus.rx_bit};
            crc_d = crc_shift;
            if (cnt_q == 7'd3) begin
              cnt_d   = 7'd0;
              state_d = (data_len == 7'd0) ? S_CRC : S_DATA;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_DATA: begin
            // Bits land from bit 63 downward so the first byte is [63:56]
            // and bytes never received stay zero.
            data_d[6'(7'd63 - cnt_q)] = bus.rx_bit;
            crc_d = crc_shift;
            if (cnt_q == data_len - 7'd1) begin
              state_d = S_CRC;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_CRC: begin
            crc_d = crc_shift;
            if (cnt_q == 7'd14) begin
              // The tail from CRC_DEL on is fixed-form and never stuffed.
              bypass_d = 1'b1;
              state_d  = S_CRC_DEL;
              cnt_d    = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_CRC_DEL: begin
            if (!bus.rx_bit) begin
              form_err_d = 1'b1;
              go_error   = 1'b1;
            end else if (crc_q != 15'd0) begin
              crc_err_d = 1'b1;
              go_error  = 1'b1;
            end else begin
              ack_d   = 1'b1;
              state_d = S_ACK;
            end
          end
          S_ACK: begin
            state_d = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!bus.rx_bit) begin
              form_err_d = 1'b1;
              go_error   = 1'b1;
            end else begin
              state_d = S_EOF;
              cnt_d   = 7'd0;
            end
          end
          S_EOF: begin
            if (!bus.rx_bit) begin
              form_err_d = 1'b1;
              go_error   = 1'b1;
            end else if (cnt_q == 7'd6) begin
              fid_d      = 29'(id_q);
              frtr_d     = rtr_q;
              fdlc_d     = dlc_q;
              fdata_d    = data_q;
`ifdef CAN_EXT_ID_EN
              fide_d     = ide_q;
`endif
              fv_d       = 1'b1;
              state_d    = S_IDLE;
              idle_cnt_d = IDLE_MAX;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_ERROR: begin
            if (bus.rx_bit) begin
              if (idle_cnt_q == IDLE_MAX - 1'b1) begin
                state_d    = S_IDLE;
                idle_cnt_d = IDLE_MAX;
              end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
              end
            end else begin
              idle_cnt_d = '0;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end

      if (go_error) begin
        state_d    = S_ERROR;
        idle_cnt_d = '0;
        bypass_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idle_cnt_q  <= '0;
      cnt_q       <= 7'd0;
      crc_q       <= 15'd0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= 4'd0;
      data_q      <= 64'd0;
      bypass_q    <= 1'b1;
      ack_q       <= 1'b0;
      fv_q        <= 1'b0;
      crc_err_q   <= 1'b0;
      form_err_q  <= 1'b0;
      stuff_err_q <= 1'b0;
      fid_q       <= 29'd0;
      frtr_q      <= 1'b0;
      fdlc_q      <= 4'd0;
      fdata_q     <= 64'd0;
`ifdef CAN_EXT_ID_EN
      ide_q       <= 1'b0;
      fide_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
      bypass_q    <= bypass_d;
      ack_q       <= ack_d;
      fv_q        <= fv_d;
      crc_err_q   <= crc_err_d;
      form_err_q  <= form_err_d;
      stuff_err_q <= stuff_err_d;
      fid_q       <= fid_d;
      frtr_q      <= frtr_d;
      fdlc_q      <= fdlc_d;
      fdata_q     <= fdata_d;
`ifdef CAN_EXT_ID_EN
      ide_q       <= ide_d;
      fide_q      <= fide_d;
`endif
    end
  end

  assign bus.stuff_bypass   = bypass_q;
  assign bus.busy           = in_frame;
  assign bus.ack_slot       = ack_q;
  assign bus.frame_valid    = fv_q;
  assign bus.frame_id       = fid_q;
  assign bus.frame_rtr      = frtr_q;
  assign bus.frame_dlc      = fdlc_q;
  assign bus.frame_data     = fdata_q;
  assign bus.crc_error      = crc_err_q;
  assign bus.form_error     = form_err_q;
  assign bus.stuff_err_flag = stuff_err_q;
`ifdef CAN_EXT_ID_EN
  assign bus.frame_ide      = fide_q;
`else
  assign bus.frame_ide      = 1'b0;
`endif

endmodule
